// File: rtl/npu_seq_pkg.sv
// Shared types and constants for the NPU sequencer.
// State encoding is visible to software through state_o.
package npu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      NPU_RST = 3'd1,
      CONFIG  = 3'd2,
      RUN     = 3'd3,
      DRAIN   = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam int CTL_START   = 0;
   localparam int CTL_ABORT   = 1;
   localparam int CTL_SKIPCFG = 2;

   localparam int CNT_W = 15;

endpackage

// File: rtl/npu_seq_dly.sv
// DEPTH-stage delay line for a single enable bit, with a synchronous flush
// that empties every stage on the same edge.
module npu_seq_dly #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic level,
   output logic delayed
);

   logic [DEPTH-1:0] stages;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         stages <= '0;
      end else begin
         stages[0] <= level;
         for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign delayed = stages[DEPTH-1];

endmodule

// File: rtl/npu_seq_ctrl.sv
// NPU sequencer: streams parameter then image RAM addresses, aligns npu_top
// enables to the RAM read latency, and captures the final result.
module npu_seq_ctrl
   import npu_seq_pkg::*;
#(
   parameter int CFG_WORDS = 288,
   parameter int IMG_WORDS = 196,
   parameter int RD_LAT    = 1,
   parameter int PIPE_LAT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] control_reg,
   output logic        mem_rd_en,
   output logic [14:0] param_addr,
   output logic [9:0]  image_addr,
   output logic        en_config,
   output logic        en_fsm,
   output logic        npu_rst,
   input  logic [7:0]  d_out,
   output logic [7:0]  result,
   output logic        result_valid,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic [2:0]  state_o
);

   localparam logic [CNT_W-1:0] CFG_LAST   = CNT_W'(CFG_WORDS - 1);
   localparam logic [CNT_W-1:0] IMG_LAST   = CNT_W'(IMG_WORDS - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT + RD_LAT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] param_hold_q;
   logic             start_q;
   logic             start_rise;
   logic             abort_req;
   logic             accept;
   logic             capture;
   logic             abort_hit;
   logic [7:0]       result_q;
   logic             aborted_q;
   logic             unused_ctl;

   assign unused_ctl = ^control_reg[31:3];
   assign start_rise = control_reg[CTL_START] & ~start_q;
   assign abort_req  = control_reg[CTL_ABORT];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      capture   = 1'b0;
      abort_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_rise && !abort_req) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = control_reg[CTL_SKIPCFG] ? RUN : NPU_RST;
            end
         end
         NPU_RST: begin
            cnt_d   = '0;
            state_d = CONFIG;
         end
         CONFIG: begin
            if (cnt_q == CFG_LAST) begin
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (cnt_q == IMG_LAST) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               capture = 1'b1;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (!control_reg[CTL_START]) begin
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      // Abort overrides any transition, including a DRAIN completion.
      if (abort_req && (state_q inside {NPU_RST, CONFIG, RUN, DRAIN})) begin
         abort_hit = 1'b1;
         capture   = 1'b0;
         cnt_d     = '0;
         state_d   = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         start_q      <= 1'b1;
         result_q     <= '0;
         aborted_q    <= 1'b0;
         param_hold_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         start_q <= control_reg[CTL_START];
         if (capture) begin
            result_q <= d_out;
         end
         if (abort_hit) begin
            aborted_q <= 1'b1;
         end else if (accept) begin
            aborted_q <= 1'b0;
         end
         if (accept) begin
            param_hold_q <= '0;
         end else if (state_q == CONFIG) begin
            param_hold_q <= cnt_q;
         end
      end
   end

   npu_seq_dly #(.DEPTH(RD_LAT)) u_dly_cfg (
      .clk     (clk),
      .reset   (reset),
      .flush   (abort_hit),
      .level   (state_q == CONFIG),
      .delayed (en_config)
   );

   npu_seq_dly #(.DEPTH(RD_LAT)) u_dly_fsm (
      .clk     (clk),
      .reset   (reset),
      .flush   (abort_hit),
      .level   ((state_q == RUN) || (state_q == DRAIN)),
      .delayed (en_fsm)
   );

   assign mem_rd_en    = (state_q == CONFIG) || (state_q == RUN);
   assign param_addr   = (state_q == CONFIG) ? cnt_q :
                         (state_q == RUN)    ? param_hold_q : '0;
   assign image_addr   = (state_q == RUN) ? cnt_q[9:0] : '0;
   assign npu_rst      = (state_q == NPU_RST);
   assign result       = result_q;
   assign result_valid = capture;
   assign busy         = (state_q != IDLE) && (state_q != DONE);
   assign done         = (state_q == DONE);
   assign aborted      = aborted_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Directed bench for npu_seq_ctrl: small-parameter instance for cycle-exact
// traces, default-parameter instance for the full-length run.
module tb_npu_seq_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [31:0] ctl;
   logic [7:0]  dout;
   logic        mem_rd_en, en_config, en_fsm, npu_rst, result_valid, busy, done, aborted;
   logic [14:0] param_addr;
   logic [9:0]  image_addr;
   logic [7:0]  result;
   logic [2:0]  state_o;

   logic [31:0] ctl2;
   logic [7:0]  dout2;
   logic        d2_mem_rd_en, d2_en_config, d2_en_fsm, d2_npu_rst, d2_result_valid;
   logic        d2_busy, d2_done, d2_aborted;
   logic [14:0] d2_param_addr;
   logic [9:0]  d2_image_addr;
   logic [7:0]  d2_result;
   logic [2:0]  d2_state_o;

   int checks = 0;
   int fails  = 0;

   npu_seq_ctrl #(.CFG_WORDS(4), .IMG_WORDS(3), .RD_LAT(1), .PIPE_LAT(2)) dut (
      .clk(clk), .reset(reset), .control_reg(ctl), .mem_rd_en(mem_rd_en),
      .param_addr(param_addr), .image_addr(image_addr), .en_config(en_config),
      .en_fsm(en_fsm), .npu_rst(npu_rst), .d_out(dout), .result(result),
      .result_valid(result_valid), .busy(busy), .done(done), .aborted(aborted),
      .state_o(state_o)
   );

   npu_seq_ctrl dut_def (
      .clk(clk), .reset(reset), .control_reg(ctl2), .mem_rd_en(d2_mem_rd_en),
      .param_addr(d2_param_addr), .image_addr(d2_image_addr), .en_config(d2_en_config),
      .en_fsm(d2_en_fsm), .npu_rst(d2_npu_rst), .d_out(dout2), .result(d2_result),
      .result_valid(d2_result_valid), .busy(d2_busy), .done(d2_done), .aborted(d2_aborted),
      .state_o(d2_state_o)
   );

   // Expected trace for cycles 1..13 after the start edge (CFG=4, IMG=3, RD=1, PIPE=2).
   localparam logic [2:0]  T_ST [13] = '{1, 2, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5};
   localparam logic        T_NR [13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   localparam logic        T_RD [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
   localparam logic [14:0] T_PA [13] = '{0, 0, 1, 2, 3, 3, 3, 3, 0, 0, 0, 0, 0};
   localparam logic [9:0]  T_IA [13] = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0};
   localparam logic        T_EC [13] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
   localparam logic        T_EF [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
   localparam logic        T_RV [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
   localparam logic        T_DN [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
   localparam logic        T_BZ [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
   localparam logic [7:0]  T_RS [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'hA5};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      ctl = '0; ctl2 = '0; dout = '0; dout2 = '0;
      reset = 1'b1;
      tick; tick;
      checks++;
      if ({mem_rd_en, param_addr, image_addr, en_config, en_fsm, npu_rst, result,
           result_valid, busy, done, aborted, state_o} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got st=%0d rd=%b pa=%0d ia=%0d ec=%b ef=%b res=%0h exp all zero",
                  state_o, mem_rd_en, param_addr, image_addr, en_config, en_fsm, result);
      end
      checks++;
      if ({d2_mem_rd_en, d2_en_config, d2_en_fsm, d2_npu_rst, d2_done, d2_busy, d2_state_o} !== '0) begin
         fails++;
         $display("FAIL reset_outputs_def got st=%0d exp all zero", d2_state_o);
      end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_basic;
      dout = 8'hA5;
      ctl  = 32'h1;
      for (int c = 1; c <= 13; c++) begin
         tick;
         checks += 11;
         if (state_o !== T_ST[c-1]) begin fails++; $display("FAIL basic c%0d state got %0d exp %0d", c, state_o, T_ST[c-1]); end
         if (npu_rst !== T_NR[c-1]) begin fails++; $display("FAIL basic c%0d npu_rst got %b exp %b", c, npu_rst, T_NR[c-1]); end
         if (mem_rd_en !== T_RD[c-1]) begin fails++; $display("FAIL basic c%0d mem_rd_en got %b exp %b", c, mem_rd_en, T_RD[c-1]); end
         if (param_addr !== T_PA[c-1]) begin fails++; $display("FAIL basic c%0d param_addr got %0d exp %0d", c, param_addr, T_PA[c-1]); end
         if (image_addr !== T_IA[c-1]) begin fails++; $display("FAIL basic c%0d image_addr got %0d exp %0d", c, image_addr, T_IA[c-1]); end
         if (en_config !== T_EC[c-1]) begin fails++; $display("FAIL basic c%0d en_config got %b exp %b", c, en_config, T_EC[c-1]); end
         if (en_fsm !== T_EF[c-1]) begin fails++; $display("FAIL basic c%0d en_fsm got %b exp %b", c, en_fsm, T_EF[c-1]); end
         if (result_valid !== T_RV[c-1]) begin fails++; $display("FAIL basic c%0d result_valid got %b exp %b", c, result_valid, T_RV[c-1]); end
         if (done !== T_DN[c-1]) begin fails++; $display("FAIL basic c%0d done got %b exp %b", c, done, T_DN[c-1]); end
         if (busy !== T_BZ[c-1]) begin fails++; $display("FAIL basic c%0d busy got %b exp %b", c, busy, T_BZ[c-1]); end
         if (result !== T_RS[c-1]) begin fails++; $display("FAIL basic c%0d result got %0h exp %0h", c, result, T_RS[c-1]); end
      end
      ctl = 32'h0;
      tick;
      checks++;
      if (state_o !== 3'd0) begin fails++; $display("FAIL basic_to_idle state got %0d exp 0", state_o); end
   endtask

   task automatic test_skip_config;
      logic [2:0] est;
      dout = 8'h3C;
      ctl  = 32'h5;
      for (int c = 1; c <= 8; c++) begin
         tick;
         est = (c <= 3) ? 3'd3 : (c <= 6) ? 3'd4 : 3'd5;
         checks += 6;
         if (state_o !== est) begin fails++; $display("FAIL skip c%0d state got %0d exp %0d", c, state_o, est); end
         if (npu_rst !== 1'b0 || en_config !== 1'b0) begin fails++; $display("FAIL skip c%0d npu_rst/en_config got %b%b exp 00", c, npu_rst, en_config); end
         if (image_addr !== ((c <= 3) ? 10'(c - 1) : 10'd0)) begin fails++; $display("FAIL skip c%0d image_addr got %0d", c, image_addr); end
         if (en_fsm !== (c >= 2 && c <= 7)) begin fails++; $display("FAIL skip c%0d en_fsm got %b", c, en_fsm); end
         if (result_valid !== (c == 6)) begin fails++; $display("FAIL skip c%0d result_valid got %b", c, result_valid); end
         if (done !== (c >= 7)) begin fails++; $display("FAIL skip c%0d done got %b", c, done); end
      end
      checks++;
      if (result !== 8'h3C) begin fails++; $display("FAIL skip_result got %0h exp 3c", result); end
      ctl = 32'h0;
      tick;
   endtask

   task automatic test_abort;
      logic saw_rv;
      dout = 8'h77;
      ctl  = 32'h1;
      repeat (7) tick;
      checks++;
      if (state_o !== 3'd3 || image_addr !== 10'd1) begin
         fails++; $display("FAIL abort_setup got st=%0d ia=%0d exp st=3 ia=1", state_o, image_addr);
      end
      ctl = 32'h3;
      tick;
      checks += 4;
      if (state_o !== 3'd0) begin fails++; $display("FAIL abort_state got %0d exp 0", state_o); end
      if (mem_rd_en !== 1'b0) begin fails++; $display("FAIL abort_rd_en got %b exp 0", mem_rd_en); end
      if (en_fsm !== 1'b0) begin fails++; $display("FAIL abort_en_fsm got %b exp 0", en_fsm); end
      if (aborted !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL abort_status got ab=%b busy=%b exp 1 0", aborted, busy); end
      ctl = 32'h0;
      saw_rv = 1'b0;
      repeat (5) begin
         tick;
         if (result_valid) saw_rv = 1'b1;
      end
      checks += 2;
      if (saw_rv !== 1'b0) begin fails++; $display("FAIL abort_no_valid got %b exp 0", saw_rv); end
      if (result !== 8'h3C || aborted !== 1'b1) begin fails++; $display("FAIL abort_hold got res=%0h ab=%b exp 3c 1", result, aborted); end
      ctl = 32'h1;
      tick;
      checks++;
      if (aborted !== 1'b0 || state_o !== 3'd1) begin fails++; $display("FAIL abort_restart got ab=%b st=%0d exp 0 1", aborted, state_o); end
   endtask

   task automatic test_done_hold;
      int n;
      n = 0;
      while (!done && n < 60) begin
         tick;
         n++;
      end
      checks += 2;
      if (done !== 1'b1) begin fails++; $display("FAIL done_timeout got done=%b after %0d cycles exp 1", done, n); end
      if (result !== 8'h77) begin fails++; $display("FAIL done_result got %0h exp 77", result); end
      for (int k = 0; k < 10; k++) begin
         tick;
         checks++;
         if (state_o !== 3'd5 || busy !== 1'b0) begin fails++; $display("FAIL done_hold k%0d got st=%0d busy=%b exp 5 0", k, state_o, busy); end
      end
      ctl = 32'h0;
      tick;
      checks++;
      if (state_o !== 3'd0) begin fails++; $display("FAIL done_release got %0d exp 0", state_o); end
      ctl = 32'h2;
      tick;
      checks++;
      if (aborted !== 1'b0 || state_o !== 3'd0) begin fails++; $display("FAIL idle_abort got ab=%b st=%0d exp 0 0", aborted, state_o); end
      ctl = 32'h3;
      tick;
      checks++;
      if (state_o !== 3'd0 || aborted !== 1'b0) begin fails++; $display("FAIL abort_beats_start got st=%0d ab=%b exp 0 0", state_o, aborted); end
      ctl = 32'h0;
      tick;
   endtask

   task automatic test_start_held;
      ctl   = 32'h1;
      reset = 1'b1;
      tick; tick;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++;
         if (state_o !== 3'd0) begin fails++; $display("FAIL held_start k%0d state got %0d exp 0", k, state_o); end
      end
      ctl = 32'h0;
      tick;
      ctl = 32'h1;
      tick;
      checks++;
      if (state_o !== 3'd1 || npu_rst !== 1'b1) begin fails++; $display("FAIL held_restart got st=%0d nr=%b exp 1 1", state_o, npu_rst); end
   endtask

   task automatic test_reset_mid;
      dout = 8'h99;
      repeat (3) tick;
      reset = 1'b1;
      tick;
      checks++;
      if ({mem_rd_en, param_addr, image_addr, en_config, en_fsm, npu_rst, result,
           result_valid, busy, done, aborted, state_o} !== '0) begin
         fails++;
         $display("FAIL reset_mid got st=%0d pa=%0d ec=%b res=%0h exp all zero", state_o, param_addr, en_config, result);
      end
      ctl   = 32'h0;
      reset = 1'b0;
      tick;
   endtask

   task automatic test_default_full;
      int ec, ef, n;
      logic [14:0] last_pa;
      logic [9:0]  last_ia;
      ec = 0; ef = 0; n = 0; last_pa = '0; last_ia = '0;
      dout2 = 8'h5A;
      ctl2  = 32'h1;
      while (!d2_done && n < 1000) begin
         tick;
         n++;
         if (d2_en_config) ec++;
         if (d2_en_fsm) ef++;
         if (d2_state_o == 3'd3) begin
            last_pa = d2_param_addr;
            last_ia = d2_image_addr;
         end
      end
      checks += 6;
      if (d2_done !== 1'b1) begin fails++; $display("FAIL full_timeout got done=%b after %0d cycles exp 1", d2_done, n); end
      if (ec != 288) begin fails++; $display("FAIL full_en_config got %0d exp 288", ec); end
      if (ef != 213) begin fails++; $display("FAIL full_en_fsm got %0d exp 213", ef); end
      if (last_pa !== 15'd287) begin fails++; $display("FAIL full_param_addr got %0d exp 287", last_pa); end
      if (last_ia !== 10'd195) begin fails++; $display("FAIL full_image_addr got %0d exp 195", last_ia); end
      if (d2_result !== 8'h5A) begin fails++; $display("FAIL full_result got %0h exp 5a", d2_result); end
      ctl2 = 32'h0;
      tick;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_skip_config;
      test_abort;
      test_done_hold;
      test_start_held;
      test_reset_mid;
      test_default_full;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/npu_seq_ctrl.md
Name: npu_seq_ctrl

Overview:
- Sequencer for the NPU datapath: memory read path, image/param RAMs and npu_top.
- Decodes start/abort/skip bits from the software control register.
- Issues read addresses for parameter RAM (config phase) and image RAMs (run phase), and drives npu_top EN_CONFIG/EN_FSM aligned to RAM read latency.
- Captures the final D_OUT result and reports busy/done/abort status back to the bus.

Parameters:
- CFG_WORDS, 288: parameter-RAM words streamed during config, 1..32768.
- IMG_WORDS, 196: image-RAM words per inference; 4 banks x 196 = 784 pixels. Range 1..1024.
- RD_LAT, 1: RAM read latency in cycles, 1..4.
- PIPE_LAT, 16: cycles after the last image beat until D_OUT is valid, 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- control_reg  in  32  [0] start (rising edge), [1] abort (level), [2] skip_config
- mem_rd_en  out  1  read strobe toward the RAM read path
- param_addr  out  15  parameter/conv RAM read address
- image_addr  out  10  image RAM read address, shared by banks 0-3
- en_config  out  1  to npu_top EN_CONFIG
- en_fsm  out  1  to npu_top EN_FSM
- npu_rst  out  1  one-cycle datapath clear, ORed with reset at npu_top RST_GLO
- d_out  in  8  npu_top D_OUT
- result  out  8  captured inference result
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE
- aborted  out  1  sticky; set by abort, cleared by next accepted start
- state_o  out  3  current state encoding, for a status register

Behaviour:
- Reset (sync, active-high): state IDLE; all outputs 0; counter 0; delay lines cleared.
- start_q resets to 1, so a start bit held high across reset does not trigger; start_rise = control_reg[0] & ~start_q.
- IDLE:
  - start_rise with [2]=0 -> NPU_RST.
  - start_rise with [2]=1 -> RUN.
  - An accepted start clears aborted.
- NPU_RST: npu_rst=1 for exactly one cycle -> CONFIG; cnt=0.
- CONFIG:
  - mem_rd_en=1; param_addr=cnt; cnt increments every cycle.
  - When cnt==CFG_WORDS-1 -> RUN; cnt=0.
- RUN:
  - mem_rd_en=1; image_addr=cnt[9:0]; param_addr holds its last value.
  - When cnt==IMG_WORDS-1 -> DRAIN; cnt=0.
- DRAIN:
  - mem_rd_en=0; cnt counts to PIPE_LAT+RD_LAT-1.
  - At that count: result<=d_out, result_valid=1 for one cycle, -> DONE.
- DONE: done=1, busy=0; -> IDLE when control_reg[0]==0. No restart without the start bit dropping first.
- Delay alignment:
  - en_config = (state==CONFIG) delayed exactly RD_LAT cycles.
  - en_fsm = (state==RUN or DRAIN) delayed RD_LAT cycles.
  - Result: each is high for exactly CFG_WORDS and IMG_WORDS+PIPE_LAT+RD_LAT cycles respectively.
- Abort:
  - control_reg[1]=1 in NPU_RST/CONFIG/RUN/DRAIN -> IDLE next cycle.
  - Delay lines flushed the same edge, so en_config/en_fsm drop in 1 cycle.
  - aborted=1; result and result_valid are not updated.
  - Abort in IDLE/DONE is ignored.
  - Abort and start_rise together in IDLE: abort wins; start is ignored.
- Reset mid-operation: identical to reset from idle; no partial result is produced.
- Addresses are 0 outside their active states. The counter never wraps; terminal compares are exact.

Decomposition:
- Package npu_seq_pkg:
  - state_t enum: IDLE=0, NPU_RST=1, CONFIG=2, RUN=3, DRAIN=4, DONE=5.
  - Control bit index constants: CTL_START=0, CTL_ABORT=1, CTL_SKIPCFG=2.
  - CNT_W=15.
- Sub-module npu_seq_dly: parameterised RD_LAT-deep shift register with sync flush. Instantiated twice, for en_config and en_fsm.

Test Plan:
1. Bench params CFG_WORDS=4, IMG_WORDS=3, RD_LAT=1, PIPE_LAT=2; write start 0->1.
   - npu_rst pulses on cycle 1.
   - param_addr 0,1,2,3 on cycles 2-5; en_config high cycles 3-6.
   - image_addr 0,1,2 on cycles 6-8; en_fsm high cycles 7-12.
   - result_valid pulses on cycle 11 with result = d_out driven as 8'hA5.
   - done=1 from cycle 12.
2. Start with skip_config=1:
   - No npu_rst and no en_config.
   - image_addr 0..2 starts the cycle after the edge; done follows 6 cycles later.
3. Abort asserted mid-RUN at image_addr=1:
   - Next cycle state IDLE, mem_rd_en=0; en_fsm low 1 cycle later.
   - aborted=1; result_valid never pulses.
   - Next start clears aborted.
4. control_reg[0] held high through reset release -> stays IDLE. Drop to 0 then 1 -> sequence starts.
5. In DONE, keep start=1 for 10 cycles -> remains DONE, no new run. Drop start -> IDLE one cycle later.
6. Default params, full run -> exactly 288 en_config cycles and 196+16+1=213 en_fsm cycles; param_addr ends at 287, image_addr ends at 195.
